// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding,
// frame bit levels, legal oversample ratios and parity types.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples; emits a registered
// decision strobe and majority-voted bit one cycle after the last sample.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      i_rx,
    input  logic                      i_active,
    input  logic                      i_clear,
    input  logic [PRESCALE_WIDTH-1:0] i_presc,
    output logic                      o_wrap,
    output logic                      o_strobe,
    output logic                      o_bit
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic                      r_s0;
    logic                      r_s1;
    logic                      r_strobe;
    logic                      r_bit;

    assign w_half   = i_presc >> 1;
    assign o_wrap   = i_active && (r_cnt == i_presc - ONE);
    assign o_strobe = r_strobe;
    assign o_bit    = r_bit;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt    <= '0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_strobe <= 1'b0;
            r_bit    <= 1'b1;
        end else begin
            r_strobe <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_active) begin
                r_cnt <= o_wrap ? '0 : r_cnt + ONE;
                if (r_cnt == w_half - ONE)
                    r_s0 <= i_rx;
                if (r_cnt == w_half)
                    r_s1 <= i_rx;
                // third sample is voted directly off the line
                if (r_cnt == w_half + ONE) begin
                    r_strobe <= 1'b1;
                    r_bit    <= majority3(r_s0, r_s1, i_rx);
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: frame FSM, shift register, parity/stop checks.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on RX_IN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      Parity_EN,
    input  logic                      Parity_type,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_valid,
    output logic                      Parity_error,
    output logic                      Stop_error,
    output logic                      Busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] B_ONE = BW'(1);

    logic                      w_rx;
    rx_state_e                 r_state;
    rx_state_e                 w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] w_presc;
    logic                      r_par_en;
    logic                      r_par_type;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [DATA_WIDTH-1:0]     w_shift;
    logic [BW-1:0]             r_bitcnt;
    logic [BW-1:0]             w_bitcnt;
    logic                      r_par_err;
    logic                      w_par_err;
    logic                      w_par_exp;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DATA_WIDTH-1:0]     w_data;
    logic                      r_valid;
    logic                      w_valid;
    logic                      r_perr;
    logic                      w_perr;
    logic                      r_serr;
    logic                      w_serr;
    logic                      w_start;
    logic                      w_wrap;
    logic                      w_strobe;
    logic                      w_bit;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            r_sync <= 2'b11;
        else
            r_sync <= {r_sync[0], RX_IN};
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .CLK     (CLK),
        .Reset   (Reset),
        .i_rx    (w_rx),
        .i_active(r_state != ST_IDLE),
        .i_clear (w_start),
        .i_presc (r_presc),
        .o_wrap  (w_wrap),
        .o_strobe(w_strobe),
        .o_bit   (w_bit)
    );

    // anything other than 16 or 32 runs at the base ratio of 8
    always_comb begin
        w_presc = PRESCALE_WIDTH'(PRESC_8);
        if (Prescale == PRESCALE_WIDTH'(PRESC_16) ||
            Prescale == PRESCALE_WIDTH'(PRESC_32))
            w_presc = Prescale;
    end

    assign w_par_exp = (r_par_type == ODD) ? ~^r_shift : ^r_shift;

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = r_shift;
        w_bitcnt    = r_bitcnt;
        w_par_err   = r_par_err;
        w_data      = r_data;
        w_valid     = 1'b0;
        w_perr      = 1'b0;
        w_serr      = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rx == START_BIT) begin
                    w_state_nxt = ST_START;
                    w_start     = 1'b1;
                    w_bitcnt    = '0;
                    w_par_err   = 1'b0;
                end
            end
            ST_START: begin
                if (w_strobe && w_bit != START_BIT)
                    w_state_nxt = ST_IDLE;
                else if (w_wrap)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_strobe)
                    w_shift = {w_bit, r_shift[DATA_WIDTH-1:1]};
                if (w_wrap) begin
                    if (r_bitcnt == LAST) begin
                        w_bitcnt    = '0;
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bitcnt = r_bitcnt + B_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (w_strobe)
                    w_par_err = (w_bit != w_par_exp);
                if (w_wrap)
                    w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // resolve at mid-stop so a back-to-back start is not missed
                if (w_strobe) begin
                    w_state_nxt = ST_IDLE;
                    if (w_bit != STOP_BIT) begin
                        w_serr = 1'b1;
                    end else if (r_par_err) begin
                        w_perr = 1'b1;
                    end else begin
                        w_valid = 1'b1;
                        w_data  = r_shift;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_presc    <= PRESCALE_WIDTH'(PRESC_8);
            r_par_en   <= 1'b0;
            r_par_type <= EVEN;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par_err  <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift;
            r_bitcnt  <= w_bitcnt;
            r_par_err <= w_par_err;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_perr    <= w_perr;
            r_serr    <= w_serr;
            if (w_start) begin
                r_presc    <= w_presc;
                r_par_en   <= Parity_EN;
                r_par_type <= Parity_type;
            end
        end
    end

    assign P_DATA       = r_data;
    assign Data_valid   = r_valid;
    assign Parity_error = r_perr;
    assign Stop_error   = r_serr;
    assign Busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are pushed as expected
// pulses when driven and matched against pulses captured at negedge.
module tb_uart_rx_core;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    localparam logic [2:0] K_DV = 3'b100;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_SE = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         start;
        int         lat;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Parity_EN;
    logic       Parity_type;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [2:0] obs_kind [0:63];
    logic [7:0] obs_data [0:63];
    int         obs_cyc  [0:63];
    int         wr = 0;
    int         rd = 0;

    exp_t       exp_q[$];
    logic [7:0] last_good;

    uart_rx_core dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .Parity_EN   (Parity_EN),
        .Parity_type (Parity_type),
        .P_DATA      (P_DATA),
        .Data_valid  (Data_valid),
        .Parity_error(Parity_error),
        .Stop_error  (Stop_error),
        .Busy        (Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if ((Data_valid || Parity_error || Stop_error) && wr < 64) begin
            obs_kind[wr] = {Data_valid, Parity_error, Stop_error};
            obs_data[wr] = P_DATA;
            obs_cyc[wr]  = cyc;
            wr           = wr + 1;
        end
    end

    // Called right after a posedge; drives one frame bit per p cycles.
    task automatic send_frame(
        input  logic [7:0] d,
        input  int         p,
        input  int         presc,
        input  logic       pe,
        input  logic       pt,
        input  logic       bad_par,
        input  logic       stop_v,
        input  logic       glitch,
        input  logic       scramble,
        output int         st
    );
        logic [10:0] bits;
        logic        par;
        int          nb;
        par = pt ? ~^d : ^d;
        if (bad_par)
            par = ~par;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            bits[i+1] = d[i];
        if (pe) begin
            bits[9]  = par;
            bits[10] = stop_v;
            nb       = 11;
        end else begin
            bits[9] = stop_v;
            nb      = 10;
        end
        st = 0;
        for (int b = 0; b < nb; b++) begin
            #1;
            if (b == 0) begin
                Prescale    = presc[5:0];
                Parity_EN   = pe;
                Parity_type = pt;
                st          = cyc + 1;
            end
            if (b == 1 && scramble) begin
                Prescale    = 6'd16;
                Parity_EN   = ~pe;
                Parity_type = ~pt;
            end
            RX_IN = bits[b];
            if (glitch && b >= 1 && b <= 8) begin
                repeat (p / 2 + 1) @(posedge CLK);
                #1 RX_IN = ~bits[b];
                @(posedge CLK);
                #1 RX_IN = bits[b];
                repeat (p - p / 2 - 2) @(posedge CLK);
            end else begin
                repeat (p) @(posedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        Reset       = 1'b0;
        RX_IN       = 1'b1;
        Prescale    = 6'd8;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        last_good   = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({P_DATA, Data_valid, Parity_error, Stop_error, Busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got P_DATA=%h dv=%b pe=%b se=%b busy=%b, need all 0",
                     P_DATA, Data_valid, Parity_error, Stop_error, Busy);
        end
        @(posedge CLK);
        #1 Reset = 1'b1;
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_parity_good();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'hA5, 8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
        exp_q.push_back('{K_DV, 8'hA5, st, 87 + SYNC});
        last_good = 8'hA5;
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL par_good_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind) begin
                errors++;
                $display("FAIL par_good_kind: got %b, need %b", obs_kind[rd], e.kind);
            end
            checks++;
            if (obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL par_good_data: got %h, need %h", obs_data[rd], e.data);
            end
            checks++;
            if (obs_cyc[rd] - e.start != e.lat) begin
                errors++;
                $display("FAIL par_good_latency: got %0d, need %0d", obs_cyc[rd] - e.start, e.lat);
            end
            rd++;
        end
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL par_good_busy: got %b, need 0", Busy);
        end
    endtask

    task automatic test_parity_error();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'hA5, 8, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, st);
        exp_q.push_back('{K_PE, last_good, st, 87 + SYNC});
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL par_err_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind) begin
                errors++;
                $display("FAIL par_err_kind: got %b, need %b", obs_kind[rd], e.kind);
            end
            checks++;
            if (obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL par_err_hold: got %h, need %h", obs_data[rd], e.data);
            end
            rd++;
        end
        repeat (20) @(posedge CLK);
        checks++;
        if (wr != rd) begin
            errors++;
            $display("FAIL par_err_extra: got %0d extra pulses, need 0", wr - rd);
            rd = wr;
        end
    endtask

    task automatic test_stop_error();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'h3C, 16, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
        #1 RX_IN = 1'b1;
        exp_q.push_back('{K_SE, last_good, st, 155 + SYNC});
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL stop_err_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind) begin
                errors++;
                $display("FAIL stop_err_kind: got %b, need %b", obs_kind[rd], e.kind);
            end
            checks++;
            if (obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL stop_err_hold: got %h, need %h", obs_data[rd], e.data);
            end
            checks++;
            if (obs_cyc[rd] - e.start != e.lat) begin
                errors++;
                $display("FAIL stop_err_latency: got %0d, need %0d", obs_cyc[rd] - e.start, e.lat);
            end
            rd++;
        end
        for (int t = 0; t < 100 && Busy !== 1'b0; t++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        checks++;
        if (Busy !== 1'b0 || wr != rd) begin
            errors++;
            $display("FAIL stop_err_recover: got busy=%b pulses=%0d, need 0 and 0", Busy, wr - rd);
            rd = wr;
        end
        @(posedge CLK);
        send_frame(8'h55, 16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
        exp_q.push_back('{K_DV, 8'h55, st, 155 + SYNC});
        last_good = 8'h55;
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL after_stop_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind || obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL after_stop_frame: got %b/%h, need %b/%h",
                         obs_kind[rd], obs_data[rd], e.kind, e.data);
            end
            rd++;
        end
    endtask

    task automatic test_glitch();
        logic seen;
        Prescale  = 6'd16;
        Parity_EN = 1'b0;
        @(posedge CLK);
        #1 RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RX_IN = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge CLK);
            seen = (Busy === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL glitch_busy_rise: got busy never high, need high");
        end
        for (int t = 0; t < 40 && Busy !== 1'b0; t++) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_fall: got %b, need 0", Busy);
        end
        repeat (40) @(posedge CLK);
        checks++;
        if (wr != rd) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d pulses, need 0", wr - rd);
            rd = wr;
        end
    endtask

    task automatic test_illegal_prescale();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'h3C, 8, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, st);
        exp_q.push_back('{K_DV, 8'h3C, st, 79 + SYNC});
        last_good = 8'h3C;
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL illegal_presc_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind || obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL illegal_presc_frame: got %b/%h, need %b/%h",
                         obs_kind[rd], obs_data[rd], e.kind, e.data);
            end
            checks++;
            if (obs_cyc[rd] - e.start != e.lat) begin
                errors++;
                $display("FAIL illegal_presc_latency: got %0d, need %0d", obs_cyc[rd] - e.start, e.lat);
            end
            rd++;
        end
    endtask

    task automatic test_back_to_back();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'h00, 16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
        exp_q.push_back('{K_DV, 8'h00, st, 155 + SYNC});
        send_frame(8'hFF, 16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
        exp_q.push_back('{K_DV, 8'hFF, st, 155 + SYNC});
        last_good = 8'hFF;
        for (int n = 0; n < 2; n++) begin
            e = exp_q.pop_front();
            for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
            checks++;
            if (wr == rd) begin
                errors++;
                $display("FAIL b2b_timeout: frame %0d no pulse, need kind %b", n, e.kind);
            end else begin
                checks++;
                if (obs_kind[rd] !== e.kind || obs_data[rd] !== e.data) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: got %b/%h, need %b/%h",
                             n, obs_kind[rd], obs_data[rd], e.kind, e.data);
                end
                checks++;
                if (obs_cyc[rd] - e.start != e.lat) begin
                    errors++;
                    $display("FAIL b2b_latency%0d: got %0d, need %0d", n, obs_cyc[rd] - e.start, e.lat);
                end
                rd++;
            end
        end
    endtask

    task automatic test_majority();
        int   st;
        exp_t e;
        @(posedge CLK);
        send_frame(8'h81, 32, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, st);
        exp_q.push_back('{K_DV, 8'h81, st, 339 + SYNC});
        last_good = 8'h81;
        e = exp_q.pop_front();
        for (int t = 0; t < 100 && wr == rd; t++) @(posedge CLK);
        checks++;
        if (wr == rd) begin
            errors++;
            $display("FAIL majority_timeout: no pulse seen, need kind %b", e.kind);
        end else begin
            checks++;
            if (obs_kind[rd] !== e.kind || obs_data[rd] !== e.data) begin
                errors++;
                $display("FAIL majority_frame: got %b/%h, need %b/%h",
                         obs_kind[rd], obs_data[rd], e.kind, e.data);
            end
            checks++;
            if (obs_cyc[rd] - e.start != e.lat) begin
                errors++;
                $display("FAIL majority_latency: got %0d, need %0d", obs_cyc[rd] - e.start, e.lat);
            end
            rd++;
        end
    endtask

    task automatic test_reset_mid();
        Prescale    = 6'd32;
        Parity_EN   = 1'b1;
        Parity_type = 1'b1;
        @(posedge CLK);
        #1 RX_IN = 1'b0;
        repeat (32) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (20) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        checks++;
        if ({P_DATA, Data_valid, Parity_error, Stop_error, Busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got P_DATA=%h dv=%b pe=%b se=%b busy=%b, need all 0",
                     P_DATA, Data_valid, Parity_error, Stop_error, Busy);
        end
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;
        repeat (400) @(posedge CLK);
        checks++;
        if (wr != rd || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_silent: got pulses=%0d busy=%b, need 0 and 0", wr - rd, Busy);
            rd = wr;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d pending, need 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_parity_good();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_illegal_prescale();
        test_back_to_back();
        test_majority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Oversampling UART receiver; the receive-side counterpart to the team's UART transmitter (frame: start 0, 8 data bits LSB-first, optional parity, one stop 1).
- Sits between the serial pin domain (already in CLK domain or synchronized) and the system register file / FIFO.
- Recovers bytes using majority-vote mid-bit sampling, checks parity and stop bit, and emits a one-cycle valid pulse per good frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of Prescale input (supports 8/16/32)

Ports:
- CLK  input  1  oversampling clock (Prescale × baud)
- Reset  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high
- Prescale  input  PRESCALE_WIDTH  oversample ratio; legal 8, 16, 32
- Parity_EN  input  1  1 = frame carries parity bit
- Parity_type  input  1  0 = even, 1 = odd
- P_DATA  output  DATA_WIDTH  received byte
- Data_valid  output  1  one-cycle pulse, P_DATA good
- Parity_error  output  1  one-cycle pulse, parity mismatch
- Stop_error  output  1  one-cycle pulse, stop bit sampled 0
- Busy  output  1  high while a frame is being received

Behaviour:
- Reset (async, Reset=0): FSM → IDLE; P_DATA=0, Data_valid=0, Parity_error=0, Stop_error=0, Busy=0; counters cleared. Reset mid-frame aborts silently, with no pulses.
- Config latch: Prescale, Parity_EN and Parity_type are captured on start detection and held for the frame. Illegal Prescale is treated as 8.
- Edge counter: counts 0..Prescale-1 per bit period. Bit counter advances on wrap.
- Sampling: RX_IN is sampled at edge counts P/2-1, P/2 and P/2+1. Bit value = majority of 3, decided at edge count P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN=0 → START with edge count 0, Busy=1 from the next cycle.
- START: decided bit 1 → glitch, return to IDLE (no outputs). Decided bit 0 → DATA at the edge wrap.
- DATA: bits shifted in LSB-first into the shift register. After bit DATA_WIDTH-1 wraps → PARITY if Parity_EN, else STOP.
- PARITY: expected bit = Parity_type ? ~^data : ^data. The mismatch flag is stored. Wrap → STOP.
- STOP: at the decision (P/2+1), the FSM resolves the frame and returns to IDLE. The second half of the stop bit is not waited for, which allows resync to a back-to-back start edge.
  - stop=0 → Stop_error pulse.
  - else parity mismatch → Parity_error pulse.
  - else P_DATA ← shift register and Data_valid pulse.
- Output timing: pulses are registered, high exactly one CLK, one cycle after the stop decision. P_DATA updates only on a good frame and holds otherwise. Busy falls in the same cycle as the pulse.
- Error priority: Stop_error outranks Parity_error. Only one pulse per frame.
- Latency, start falling edge → Data_valid: (9 + Parity_EN)·P + P/2 + 3 CLK, with the start edge sampled at cycle 0.
- RX_IN low while returning to IDLE: detected next cycle as a new start.
- Config changes mid-frame: ignored until the next start.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset to 1) before all logic. All latencies grow by +2 CLK.
- Undefined: RX_IN is used directly and the caller guarantees it is synchronous.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (3-bit localparams IDLE..STOP)
  - frame constants: START_BIT=0, STOP_BIT=1
  - legal prescale values PRESC_8/16/32
  - parity type encodings EVEN=0, ODD=1
- Sub-module uart_rx_sampler holds the edge counter, the 3-sample majority vote and the decision strobe. The FSM, shift register, parity check and outputs stay in uart_rx_core.

Test Plan:
- Prescale=8, Parity_EN=1 even, send 0xA5 (parity 0) → Data_valid one cycle, P_DATA=0xA5, no errors, latency 87 CLK.
- Prescale=8, even, send 0xA5 with parity bit 1 → Parity_error pulse, Data_valid never asserted, P_DATA keeps its previous value.
- Prescale=16, Parity_EN=0, 0x3C with stop bit driven 0 → Stop_error pulse only; a following good 0x55 frame is received correctly.
- RX_IN low for 3 CLK then high (Prescale=16) → glitch rejected, Busy returns 0, no pulses.
- Prescale=16, no parity, back-to-back 0x00 then 0xFF with zero idle gap → two Data_valid pulses with values 0x00, 0xFF.
- Prescale=32, odd parity, 0x81 with one sample at P/2 inverted on each data bit → P_DATA=0x81, no errors. Also assert Reset mid-DATA → all outputs 0, no pulse.
